// File: rtl/ex_hazard_ctrl_if.sv
// Signal bundle between the execute-stage hazard controller and the pipeline.
// The master side is the controller; the slave side is the pipeline or a bench.
interface ex_hazard_ctrl_if;
  logic [4:0]  rs1Id;
  logic [4:0]  rs2Id;
  logic        useRs1Id;
  logic        useRs2Id;
  logic [4:0]  rs1Ex;
  logic [4:0]  rs2Ex;
  logic [4:0]  rdEx;
  logic        memRdEx;
  logic [4:0]  rdMem;
  logic        regWrMem;
  logic        bSel;
  logic        mcReq;
  logic        mcDone;

  logic        forwardA;
  logic        forwardB;
  logic        mcStart;
  logic        stallIf;
  logic        stallId;
  logic        stallEx;
  logic        flushId;
  logic        flushEx;
  logic        mcErr;
  logic [15:0] stallCnt;

  modport master (
    input  rs1Id, rs2Id, useRs1Id, useRs2Id, rs1Ex, rs2Ex, rdEx, memRdEx,
           rdMem, regWrMem, bSel, mcReq, mcDone,
    output forwardA, forwardB, mcStart, stallIf, stallId, stallEx,
           flushId, flushEx, mcErr, stallCnt
  );

  modport slave (
    output rs1Id, rs2Id, useRs1Id, useRs2Id, rs1Ex, rs2Ex, rdEx, memRdEx,
           rdMem, regWrMem, bSel, mcReq, mcDone,
    input  forwardA, forwardB, mcStart, stallIf, stallId, stallEx,
           flushId, flushEx, mcErr, stallCnt
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: MEM->IE forwarding, load-use stall, branch
// flush, and start/done sequencing of a multi-cycle unit with a watchdog.
module ex_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rstN,
  ex_hazard_ctrl_if.master   hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MC_DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(MC_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  timer;
  logic [7:0]  timer_nxt;
  logic        mc_err_q;
  logic        err_set;
  logic [15:0] stall_cnt_q;
  logic        load_use;

  logic        mc_start;
  logic        stall_if;
  logic        stall_id;
  logic        stall_ex;
  logic        flush_id;
  logic        flush_ex;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Forwarding is independent of the sequencer state.
  assign hz.forwardA = hz.regWrMem && (hz.rdMem != 5'd0) && (hz.rdMem == hz.rs1Ex);
  assign hz.forwardB = hz.regWrMem && (hz.rdMem != 5'd0) && (hz.rdMem == hz.rs2Ex);

  assign load_use = hz.memRdEx && (hz.rdEx != 5'd0) &&
                    ((hz.useRs1Id && (hz.rdEx == hz.rs1Id)) ||
                     (hz.useRs2Id && (hz.rdEx == hz.rs2Id)));

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    err_set   = 1'b0;
    mc_start  = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    case (state)
      RUN: begin
        if (hz.mcReq) begin
          mc_start  = 1'b1;
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          timer_nxt = 8'd0;
          state_nxt = MC_WAIT;
        end else if (hz.bSel) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
      MC_WAIT: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        timer_nxt = timer + 8'd1;
        // A done pulse on the timeout cycle is a genuine completion, not an error.
        if (hz.mcDone) begin
          state_nxt = MC_DRAIN;
        end else if (timer == TMO_LAST) begin
          err_set   = 1'b1;
          state_nxt = MC_DRAIN;
        end
      end
      MC_DRAIN: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Control state: sequencer, watchdog timer, sticky error, stall counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= RUN;
      timer       <= 8'd0;
      mc_err_q    <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (err_set) begin
        mc_err_q <= 1'b1;
      end
      if (stall_if) begin
        stall_cnt_q <= sat_inc16(stall_cnt_q);
      end
    end
  end

  assign hz.mcStart  = mc_start;
  assign hz.stallIf  = stall_if;
  assign hz.stallId  = stall_id;
  assign hz.stallEx  = stall_ex;
  assign hz.flushId  = flush_id;
  assign hz.flushEx  = flush_ex;
  assign hz.mcErr    = mc_err_q;
  assign hz.stallCnt = stall_cnt_q;

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard and sequencing controller for the execute (IE) stage. It drives the IE forwarding selects (`forwardA`, `forwardB`) that choose between the register-file operand and the MEM-stage ALU result. It also generates stall and flush strobes for the IF/ID and ID/IE pipeline registers on load-use hazards and taken branches/jumps. Finally, it sequences a multi-cycle execute unit (mul/div) through a start/done handshake with a watchdog timeout.

## Interface
- `MC_TIMEOUT`, default 64: maximum number of cycles spent in MC_WAIT before a timeout is declared; legal range 2..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `rs1Id`, `rs2Id`  in  5  source register indices of the instruction in ID.
- `useRs1Id`, `useRs2Id`  in  1  the ID instruction actually reads rs1/rs2.
- `rs1Ex`, `rs2Ex`  in  5  source register indices of the instruction in IE.
- `rdEx`  in  5  destination of the IE instruction.
- `memRdEx`  in  1  the IE instruction is a load.
- `rdMem`  in  5  destination of the MEM instruction.
- `regWrMem`  in  1  the MEM instruction writes `rdMem`.
- `bSel`  in  1  branch taken or jump, from IE.
- `mcReq`  in  1  the IE instruction is a multi-cycle op.
- `mcDone`  in  1  single-cycle pulse from the multi-cycle unit: result valid.
- `forwardA`, `forwardB`  out  1  IE operand forward selects (1 = aluOutMem).
- `mcStart`  out  1  single-cycle start pulse to the multi-cycle unit.
- `stallIf`, `stallId`, `stallEx`  out  1  hold PC, IF/ID, and ID/IE respectively.
- `flushId`, `flushEx`  out  1  load a bubble into IF/ID and ID/IE respectively.
- `mcErr`  out  1  sticky timeout flag; cleared only by reset.
- `stallCnt`  out  16  saturating count of cycles in which `stallIf` was high.

## Operation
- Forwarding is combinational in all states.
  - `forwardA = regWrMem && rdMem!=0 && rdMem==rs1Ex`.
  - `forwardB` uses the same rule with `rs2Ex`.
- FSM states: RUN, MC_WAIT, MC_DRAIN. All other outputs are Mealy decodes of state and inputs.
- RUN, evaluated in priority order:
  1. Multi-cycle op: if `mcReq`, assert `mcStart`, `stallIf`, `stallId`, `stallEx`; go to MC_WAIT and clear the timer.
  2. Taken branch/jump: else if `bSel`, assert `flushId` and `flushEx`; no stall; stay in RUN.
  3. Load-use hazard: else if `memRdEx && rdEx!=0 && ((useRs1Id && rdEx==rs1Id) || (useRs2Id && rdEx==rs2Id))`, assert `stallIf`, `stallId`, `flushEx` (one bubble); stay in RUN.
- MC_WAIT:
  - Assert `stallIf`, `stallId`, `stallEx`; the timer increments each cycle.
  - If `mcDone`, go to MC_DRAIN.
  - Else if the timer reaches `MC_TIMEOUT-1`, set `mcErr` and go to MC_DRAIN; the result is garbage but the pipeline is released.
  - `bSel` and `mcReq` are ignored in this state.
- MC_DRAIN:
  - Assert `stallIf` and `stallId` only. ID/IE advances, so the result is captured by the downstream register.
  - Next state is RUN unconditionally. `mcReq` is not re-evaluated in this cycle.
- `stallCnt` increments on every cycle with `stallIf`=1 and saturates at 0xFFFF.
- Width rules: the timer is 8 bits. Register index 0 never forwards or stalls.

## Timing
- Reset (asynchronous, `rstN`=0):
  - state = RUN, timer = 0, `mcErr` = 0, `stallCnt` = 0.
  - All Mealy outputs are then driven from RUN with the current inputs.
  - Reset asserted mid-MC_WAIT aborts to RUN immediately; the multi-cycle unit is reset by the same `rstN`.
- Forward selects: zero latency, same cycle as the register-index match.
- Load-use: exactly one stall cycle. On the next cycle the load has moved to MEM, so the condition clears and `forwardA`/`forwardB` cover the dependency.
- `mcStart` is high for exactly one cycle, the RUN→MC_WAIT cycle.
- Multi-cycle stall length is the number of MC_WAIT cycles plus 2 (entry cycle + MC_DRAIN).
- `mcDone` in the same cycle as the timeout: `mcDone` wins, and `mcErr` stays 0.
- A `mcDone` pulse outside MC_WAIT is ignored.

## Test plan
- Forwarding, rs1 only: `rdMem`=5, `regWrMem`=1, `rs1Ex`=5, `rs2Ex`=6 → `forwardA`=1, `forwardB`=0 in the same cycle. Repeat with `rdMem`=0 → both 0.
- Load-use:
  - `memRdEx`=1, `rdEx`=3, `rs2Id`=3, `useRs2Id`=1 → one cycle of `stallIf`/`stallId`/`flushEx`=1, `stallCnt` 0→1.
  - Same with `useRs2Id`=0 → no stall.
- Branch beats load-use: `bSel`=1 with a simultaneous load-use match → `flushId`=`flushEx`=1, `stallIf`=0.
- Multi-cycle op: `mcReq`=1, `mcDone` pulsed 4 cycles after `mcStart` →
  - `mcStart` high for 1 cycle.
  - `stallEx` high for 5 cycles, `stallIf` for 6 cycles.
  - Returns to RUN; `mcErr`=0.
- Timeout: `MC_TIMEOUT`=8, `mcDone` never asserted → `mcErr` rises after 8 MC_WAIT cycles, MC_DRAIN follows, then RUN. `mcErr` stays 1 until `rstN` is pulsed.
- Async reset mid-wait: `rstN`=0 during MC_WAIT with no clock edge → state RUN, stalls deassert once `mcReq`=0, `stallCnt`=0.
